ps2_key_ctl: RTL and testbench
==============================

# ps2_key_ctl

PS/2 keyboard front end that receives raw PS/2 device-to-host frames and turns them into level-coded key states for the player controller. It sits directly upstream of the character motion controller. It drives that controller's `key_space`, `key_left` and `key_right` inputs, each held high for as long as the physical key is down. The block does frame reception, parity/framing checks, a frame timeout, and scan-code set 2 make/break/extended decoding.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `TIMEOUT_US`, 200: maximum gap between PS/2 clock falling edges inside one frame, in µs. `TIMEOUT_CYCLES = (CLK_FREQ/1_000_000)*TIMEOUT_US`.

Ports:
- `clk`  in  1  system clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `key_space`  out  1  high while Space is held (make 0x29).
- `key_left`  out  1  high while Left Arrow is held (E0 6B).
- `key_right`  out  1  high while Right Arrow is held (E0 74).
- `frame_err`  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- **Input sync:** `ps2_clk` and `ps2_data` each pass through 2 flops. A third flop holds the previous synced `ps2_clk`. A falling edge (`fe`) is synced-prev 1 and synced-cur 0.
- **Receiver:** `bit_cnt` runs 0..10. On each `fe`, the synced data is shifted into an 11-bit register and `bit_cnt` increments.
- **Frame completion:** on the `fe` that takes `bit_cnt` from 10, the frame is checked. It requires start=0, stop=1, and odd parity over the 8 data bits plus the parity bit. Data bits are LSB first.
  - Valid frame: `byte_valid` pulses one cycle with `byte` = data.
  - Invalid frame: `frame_err` pulses and no byte is emitted.
  - In both cases `bit_cnt` returns to 0.
- **Timeout:** `to_cnt` clears on every `fe`. It increments while `bit_cnt != 0`. When it reaches `TIMEOUT_CYCLES-1`, the partial frame is discarded, `bit_cnt` and `to_cnt` go to 0, and `frame_err` pulses. `to_cnt` holds at 0 while `bit_cnt == 0`.
- **Decoder FSM** (states `WAIT`, `BRK`, `EXT`, `EXT_BRK`), acting only on `byte_valid`:
  - `WAIT`:
    - F0 → `BRK`.
    - E0 → `EXT`.
    - 29 → set `key_space`.
    - 00 or FF (keyboard overrun) → clear all three keys.
    - Any other byte is ignored; stay in `WAIT`.
  - `BRK`: 29 → clear `key_space`. Then go to `WAIT` on any byte.
  - `EXT`:
    - F0 → `EXT_BRK`.
    - 6B → set `key_left`, then `WAIT`.
    - 74 → set `key_right`, then `WAIT`.
    - Any other byte → `WAIT`.
  - `EXT_BRK`: 6B → clear `key_left`; 74 → clear `key_right`. Then go to `WAIT` on any byte.
- **Repeated makes:** typematic repeats of a held key re-set an already-set bit, with no visible change.
- **Simultaneous keys:** `key_left` and `key_right` may both be 1. Arbitration between them belongs to the downstream controller.
- **Error recovery:** `frame_err` forces the decoder to `WAIT`, because any pending prefix is lost. Key levels are held.

## Timing
- **Reset:** `rst_n` low clears, asynchronously, every flop:
  - all key outputs = 0, `frame_err` = 0;
  - FSM = `WAIT`, `bit_cnt` = 0, `to_cnt` = 0;
  - the sync flops reset to 1, the idle bus level, so release does not create a false `fe`.
- **Reset mid-frame:** the partial frame is lost. The first frame accepted afterwards is the first one whose start bit arrives after reset release.
- **Latency:** `byte_valid` is registered on the `clk` edge that samples `fe` for the stop bit. Key outputs update on the next edge.
  - Pin-to-output latency is 4 `clk` edges after the stop-bit falling edge is first captured by sync flop 1.
  - That first capture carries ±1 cycle of asynchronous sampling uncertainty.
- **Output shape:**
  - Key outputs are registered and glitch-free; they change only on `byte_valid` or `frame_err`.
  - `frame_err` is exactly 1 cycle wide.
  - If the timeout and a final `fe` coincide in the same cycle, the `fe` wins and the frame is evaluated normally.
- **Widths:** `to_cnt` is `$clog2(TIMEOUT_CYCLES)+1` bits, `bit_cnt` is 4 bits, and the shift register is 11 bits.

## Test plan
- **Space make/break:** send frame 0x29 → `key_space` = 1 four cycles after the stop edge. Then send F0, 29 → `key_space` = 0. `key_left` and `key_right` stay 0 throughout.
- **Arrow keys:** send E0 6B, then E0 74 → `key_left` = 1 and `key_right` = 1. Send E0 F0 6B → `key_left` = 0 and `key_right` = 1. Send E0 F0 74 → both 0.
- **Parity error:** after E0, send frame 0x29 with the parity bit inverted → `frame_err` high for 1 cycle and FSM back in `WAIT`. Then send 6B → no key changes, since the E0 prefix was lost.
- **Timeout:** drive 5 bits, then hold `ps2_clk` high for 200 µs → `frame_err` pulses at `TIMEOUT_CYCLES` after the last edge. A following valid 0x29 frame sets `key_space`.
- **Overrun:** hold Space and Left, then send 0x00 → all outputs 0 on the next cycle. Repeat with 0xFF → same result.
- **Reset mid-frame:** assert `rst_n` low after 6 bits with `key_right` = 1 → all outputs 0 immediately. After release, the remaining 5 bits produce no byte, and a fresh E0 74 sets `key_right`.

Source files
------------

// File: rtl/ps2_key_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_ctl
//  Purpose  : PS/2 keyboard front end. Receives device-to-host frames,
//             checks start/stop/odd parity and inter-edge timeout, and
//             decodes scan-code set 2 make/break/extended sequences into
//             level-coded Space / Left / Right key states.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - asynchronous active-low reset
//             ps2_clk    - raw PS/2 clock pin (asynchronous)
//             ps2_data   - raw PS/2 data pin (asynchronous)
//             key_space  - high while Space is held
//             key_left   - high while Left Arrow is held
//             key_right  - high while Right Arrow is held
//             frame_err  - one-cycle pulse on parity/start/stop/timeout error
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_ctl #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int TIMEOUT_US = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic key_space,
    output logic key_left,
    output logic key_right,
    output logic frame_err
);

    localparam int C_TIMEOUT_CYCLES = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
    localparam int C_TO_W           = $clog2(C_TIMEOUT_CYCLES) + 1;
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(C_TIMEOUT_CYCLES - 1);

    localparam logic [7:0] C_BRK   = 8'hF0;
    localparam logic [7:0] C_EXT   = 8'hE0;
    localparam logic [7:0] C_SPACE = 8'h29;
    localparam logic [7:0] C_LEFT  = 8'h6B;
    localparam logic [7:0] C_RIGHT = 8'h74;
    localparam logic [7:0] C_OVR0  = 8'h00;
    localparam logic [7:0] C_OVR1  = 8'hFF;

    // ------------------------------------------------------------------
    // Input synchronisers. Reset to the idle bus level (1) so reset
    // release never looks like a falling edge.
    // ------------------------------------------------------------------
    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_dat_s1, r_dat_s2;
    logic w_fe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fe = r_clk_prev & ~r_clk_s2;

    // ------------------------------------------------------------------
    // Frame receiver. Bits arrive LSB first and are shifted in at the top,
    // so after the stop edge the frame is {stop, parity, data[7:0], start}.
    // The check is done on the shift value being written, which lets the
    // stop-bit edge itself complete the frame.
    // ------------------------------------------------------------------
    logic [10:0]       r_shift;
    logic [3:0]        r_bit_cnt;
    logic [C_TO_W-1:0] r_to_cnt;
    logic              r_byte_valid;
    logic [7:0]        r_byte;
    logic              r_frame_err;
    logic [10:0]       w_shift_nxt;
    logic              w_frame_ok;
    logic              w_unused_lsb;

    assign w_shift_nxt  = {r_dat_s2, r_shift[10:1]};
    assign w_frame_ok   = ~w_shift_nxt[0] & w_shift_nxt[10] & (^w_shift_nxt[9:1]);
    // The oldest bit simply drops off the end at the stop edge.
    assign w_unused_lsb = r_shift[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_to_cnt     <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fe) begin
                // An edge always beats a coincident timeout.
                r_to_cnt <= '0;
                r_shift  <= w_shift_nxt;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= '0;
                    if (w_frame_ok) begin
                        r_byte_valid <= 1'b1;
                        r_byte       <= w_shift_nxt[8:1];
                    end else begin
                        r_frame_err  <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == C_TO_LAST) begin
                    r_bit_cnt   <= '0;
                    r_to_cnt    <= '0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + C_TO_W'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;
    logic   r_key_space, r_key_left, r_key_right;
    logic   w_space_nxt, w_left_nxt, w_right_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_WAIT;
            r_key_space <= 1'b0;
            r_key_left  <= 1'b0;
            r_key_right <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_key_space <= w_space_nxt;
            r_key_left  <= w_left_nxt;
            r_key_right <= w_right_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_space_nxt = r_key_space;
        w_left_nxt  = r_key_left;
        w_right_nxt = r_key_right;
        if (r_frame_err) begin
            // A lost frame may have been a prefix; drop it, keep key levels.
            w_state_nxt = ST_WAIT;
        end else if (r_byte_valid) begin
            unique case (r_state)
                ST_WAIT: begin
                    if (r_byte == C_BRK) begin
                        w_state_nxt = ST_BRK;
                    end else if (r_byte == C_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else if (r_byte == C_SPACE) begin
                        w_space_nxt = 1'b1;
                    end else if (r_byte == C_OVR0 || r_byte == C_OVR1) begin
                        w_space_nxt = 1'b0;
                        w_left_nxt  = 1'b0;
                        w_right_nxt = 1'b0;
                    end
                end
                ST_BRK: begin
                    if (r_byte == C_SPACE) w_space_nxt = 1'b0;
                    w_state_nxt = ST_WAIT;
                end
                ST_EXT: begin
                    if (r_byte == C_BRK) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else begin
                        if (r_byte == C_LEFT)  w_left_nxt  = 1'b1;
                        if (r_byte == C_RIGHT) w_right_nxt = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_EXT_BRK: begin
                    if (r_byte == C_LEFT)  w_left_nxt  = 1'b0;
                    if (r_byte == C_RIGHT) w_right_nxt = 1'b0;
                    w_state_nxt = ST_WAIT;
                end
                default: w_state_nxt = ST_WAIT;
            endcase
        end
    end

    assign key_space = r_key_space;
    assign key_left  = r_key_left;
    assign key_right = r_key_right;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_ctl
//  Purpose  : Self-checking bench for ps2_key_ctl: directed scenarios plus
//             randomized key/byte/error traffic against a prefix-queue
//             reference model of the scan-code rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_ctl;

    localparam int CLK_FREQ   = 10_000_000;
    localparam int TIMEOUT_US = 200;
    localparam int T          = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
    localparam int HALF       = 10;   // clk cycles per PS/2 clock half period

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    wire  key_space, key_left, key_right, frame_err;

    ps2_key_ctl #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_US(TIMEOUT_US)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_space (key_space),
        .key_left  (key_left),
        .key_right (key_right),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_space, m_left, m_right;
    logic [7:0] pfx[$];
    int         exp_err = 0;

    task automatic model_byte(input logic [7:0] b);
        if (pfx.size() == 0) begin
            if (b == 8'hF0 || b == 8'hE0) pfx.push_back(b);
            else if (b == 8'h29) m_space = 1'b1;
            else if (b == 8'h00 || b == 8'hFF) begin
                m_space = 1'b0; m_left = 1'b0; m_right = 1'b0;
            end
        end else if (pfx.size() == 1 && pfx[0] == 8'hF0) begin
            if (b == 8'h29) m_space = 1'b0;
            pfx.delete();
        end else if (pfx.size() == 1) begin
            if (b == 8'hF0) pfx.push_back(b);
            else begin
                if (b == 8'h6B) m_left  = 1'b1;
                if (b == 8'h74) m_right = 1'b1;
                pfx.delete();
            end
        end else begin
            if (b == 8'h6B) m_left  = 1'b0;
            if (b == 8'h74) m_right = 1'b0;
            pfx.delete();
        end
    endtask

    task automatic model_err();
        exp_err++;
        pfx.delete();
    endtask

    // ---------------- frame_err monitor ----------------
    int   err_pulses = 0;
    int   err_wide   = 0;
    logic fe_prev    = 1'b0;
    always @(negedge clk) begin
        if (frame_err && !fe_prev) err_pulses++;
        if (frame_err && fe_prev)  err_wide++;
        fe_prev = frame_err;
    end

    // ---------------- stimulus helpers ----------------
    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input int kind);
        logic p;
        p = ~(^b);
        if (kind == 1) p = ~p;
        return {(kind != 2), p, b, (kind == 3)};
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] fr, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) ps2_bit(fr[i]);
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int kind = 0);
        send_bits(mk_frame(b, kind), 0, 10);
        repeat (4) @(negedge clk);
        if (kind == 0) model_byte(b);
        else           model_err();
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_space"}, key_space, m_space);
        check_eq({tag, "_left"},  key_left,  m_left);
        check_eq({tag, "_right"}, key_right, m_right);
        check_eq({tag, "_errcnt"}, err_pulses, exp_err);
    endtask

    task automatic wait_timeout(input string tag);
        int c = 0;
        while (!frame_err && c < 3 * T) begin
            @(negedge clk);
            c++;
        end
        check_eq({tag, "_seen"}, frame_err, 1);
        check_eq({tag, "_lat_ok"}, ((c + HALF) >= T) && ((c + HALF) <= T + 4), 1);
        model_err();
        repeat (5) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [10:0] fr;
        repeat (3) @(negedge clk);
        check_state("reset");
        check_eq("reset_err_lvl", frame_err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Space make with exact 4-edge latency from stop-edge capture
        fr = mk_frame(8'h29, 0);
        send_bits(fr, 0, 9);
        @(negedge clk) ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) check_eq("lat_edge3", key_space, 0);
        @(posedge clk);
        @(negedge clk) check_eq("lat_edge4", key_space, 1);
        repeat (HALF - 4) @(negedge clk);
        ps2_clk = 1'b1;
        model_byte(8'h29);
        check_state("space_make");
        send_byte(8'hF0); send_byte(8'h29);
        check_state("space_break");

        // Arrow keys
        send_byte(8'hE0); send_byte(8'h6B);
        send_byte(8'hE0); send_byte(8'h74);
        check_state("arrows_make");
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        check_state("left_break");
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        check_state("right_break");

        // Parity error drops the E0 prefix
        send_byte(8'hE0);
        send_byte(8'h29, 1);
        check_state("parity_err");
        send_byte(8'h6B);
        check_state("after_parity");

        // Timeout after 5 bits
        send_bits(mk_frame(8'h29, 0), 0, 4);
        wait_timeout("timeout");
        send_byte(8'h29);
        check_state("after_timeout");

        // Overrun codes
        send_byte(8'hE0); send_byte(8'h6B);
        check_state("pre_ovr00");
        send_byte(8'h00);
        check_state("ovr00");
        send_byte(8'h29); send_byte(8'hE0); send_byte(8'h6B);
        send_byte(8'hFF);
        check_state("ovrFF");

        // Reset in the middle of a frame
        send_byte(8'hE0); send_byte(8'h74);
        check_state("pre_rst");
        fr = mk_frame(8'h1C, 0);
        send_bits(fr, 0, 5);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check_eq("rst_space", key_space, 0);
        check_eq("rst_left",  key_left,  0);
        check_eq("rst_right", key_right, 0);
        check_eq("rst_err",   frame_err, 0);
        m_space = 1'b0; m_left = 1'b0; m_right = 1'b0;
        pfx.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_bits(fr, 6, 10);
        repeat (T + 50) @(negedge clk);
        exp_err++;   // leftover bits form a partial frame that times out
        check_state("post_rst_tail");
        send_byte(8'hE0); send_byte(8'h74);
        check_state("post_rst_right");

        // Randomized traffic
        for (int op = 0; op < 30; op++) begin
            int sel;
            int k;
            int mk;
            sel = $urandom_range(0, 10);
            if (sel <= 5) begin
                k  = $urandom_range(0, 2);
                mk = $urandom_range(0, 1);
                if (k != 0) send_byte(8'hE0);
                if (mk == 0) send_byte(8'hF0);
                send_byte(k == 0 ? 8'h29 : (k == 1 ? 8'h6B : 8'h74));
            end else if (sel == 6) begin
                send_byte(8'($urandom));
            end else if (sel == 7) begin
                send_byte($urandom_range(0, 1) ? 8'hFF : 8'h00);
            end else if (sel == 8) begin
                send_byte(8'($urandom), $urandom_range(1, 3));
            end else if (sel == 9) begin
                send_byte($urandom_range(0, 1) ? 8'hE0 : 8'hF0);
                send_byte(8'($urandom));
            end else if ($urandom_range(0, 3) == 0) begin
                send_bits(mk_frame(8'($urandom), 0), 0, $urandom_range(0, 9));
                wait_timeout("rnd_timeout");
            end
            check_state("rnd");
        end

        check_eq("err_width", err_wide, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
